// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions for the compression core and its neighbours.
//   - sha2_state_e : core FSM encoding (IDLE / RUN / DONE)
//   - sha2_rounds  : rounds per block for a given word width (64 or 80)
//   - SIG*_R*_*    : rotate amounts of the big sigma functions per word width
//   - SHA256_IV / SHA512_IV : initial hash values, A in the MSBs
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sha2_state_e;

  function automatic int unsigned sha2_rounds(input int unsigned word);
    return (word == 64) ? 80 : 64;
  endfunction

  // Sigma0(a) / Sigma1(e) rotate amounts, SHA-256
  localparam int unsigned SIG0_R0_256 = 2;
  localparam int unsigned SIG0_R1_256 = 13;
  localparam int unsigned SIG0_R2_256 = 22;
  localparam int unsigned SIG1_R0_256 = 6;
  localparam int unsigned SIG1_R1_256 = 11;
  localparam int unsigned SIG1_R2_256 = 25;
  // Sigma0(a) / Sigma1(e) rotate amounts, SHA-512
  localparam int unsigned SIG0_R0_512 = 28;
  localparam int unsigned SIG0_R1_512 = 34;
  localparam int unsigned SIG0_R2_512 = 39;
  localparam int unsigned SIG1_R0_512 = 14;
  localparam int unsigned SIG1_R1_512 = 18;
  localparam int unsigned SIG1_R2_512 = 41;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

endpackage

// File: rtl/sha2_round.sv
// One purely combinational SHA-2 round.
// Ports:
//   st_i  [8*WORD] working state {A..H}, A in MSBs
//   w_i   [WORD]   schedule word for this round
//   k_i   [WORD]   round constant for this round
//   st_o  [8*WORD] working state after the round, same packing
module sha2_round
  import sha2_pkg::*;
#(
  parameter int unsigned WORD = 32
) (
  input  logic [8*WORD-1:0] st_i,
  input  logic [WORD-1:0]   w_i,
  input  logic [WORD-1:0]   k_i,
  output logic [8*WORD-1:0] st_o
);

  localparam int unsigned S0A = (WORD == 64) ? SIG0_R0_512 : SIG0_R0_256;
  localparam int unsigned S0B = (WORD == 64) ? SIG0_R1_512 : SIG0_R1_256;
  localparam int unsigned S0C = (WORD == 64) ? SIG0_R2_512 : SIG0_R2_256;
  localparam int unsigned S1A = (WORD == 64) ? SIG1_R0_512 : SIG1_R0_256;
  localparam int unsigned S1B = (WORD == 64) ? SIG1_R1_512 : SIG1_R1_256;
  localparam int unsigned S1C = (WORD == 64) ? SIG1_R2_512 : SIG1_R2_256;

  function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD - n));
  endfunction

  logic [WORD-1:0] a, b, c, d, e, f, g, h;
  logic [WORD-1:0] sig0, sig1, ch, maj, t1, t2;

  assign a = st_i[8*WORD-1 -: WORD];
  assign b = st_i[7*WORD-1 -: WORD];
  assign c = st_i[6*WORD-1 -: WORD];
  assign d = st_i[5*WORD-1 -: WORD];
  assign e = st_i[4*WORD-1 -: WORD];
  assign f = st_i[3*WORD-1 -: WORD];
  assign g = st_i[2*WORD-1 -: WORD];
  assign h = st_i[WORD-1:0];

  assign sig0 = rotr(a, S0A) ^ rotr(a, S0B) ^ rotr(a, S0C);
  assign sig1 = rotr(e, S1A) ^ rotr(e, S1B) ^ rotr(e, S1C);
  assign ch   = (e & f) ^ (~e & g);
  assign maj  = (a & b) ^ (a & c) ^ (b & c);
  assign t1   = h + sig1 + ch + k_i + w_i;
  assign t2   = sig0 + maj;

  assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha2_compression_core.sv
// SHA-2 compression engine (SHA-256 for WORD=32, SHA-512 for WORD=64),
// UNROLL rounds per clock, owning its own round counter.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    chaining value h_in {A..H} offered / accepted (IDLE only)
//   wk_valid/wk_ready    W/K beat present / consumed (RUN only)
//   w_in, k_in           UNROLL lanes, lane 0 (LSBs) is round round_idx
//   round_idx            first round of the next beat, addresses K ROM / scheduler
//   busy                 state != IDLE
//   out_valid/out_ready  digest offered (DONE) / taken
//   digest               registered {A..H} + saved chaining value
//   dbg_state            current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready depends only on the FSM state, never on valid, and the
// core holds digest/out_valid stable until the transfer.
module sha2_compression_core
  import sha2_pkg::*;
#(
  parameter int unsigned WORD   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*WORD-1:0]      h_in,
  input  logic                   wk_valid,
  output logic                   wk_ready,
  input  logic [UNROLL*WORD-1:0] w_in,
  input  logic [UNROLL*WORD-1:0] k_in,
  output logic [6:0]             round_idx,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*WORD-1:0]      digest,
  output sha2_state_e            dbg_state
);

  localparam int unsigned ROUNDS   = sha2_rounds(WORD);
  localparam logic [6:0]  LAST_IDX = 7'(ROUNDS - UNROLL);
  localparam logic [6:0]  STEP     = 7'(UNROLL);

  sha2_state_e       state_q, state_d;
  logic [8*WORD-1:0] work_q, work_d;
  logic [8*WORD-1:0] chain_q, chain_d;
  logic [8*WORD-1:0] digest_q, digest_d;
  logic [6:0]        round_q, round_d;
  logic [8*WORD-1:0] fed_fwd;

  // stage[0] is the registered state, stage[UNROLL] the state after this beat
  logic [8*WORD-1:0] stage [UNROLL+1];
  assign stage[0] = work_q;

  for (genvar l = 0; l < UNROLL; l++) begin : g_round
    sha2_round #(.WORD(WORD)) u_round (
      .st_i (stage[l]),
      .w_i  (w_in[l*WORD +: WORD]),
      .k_i  (k_in[l*WORD +: WORD]),
      .st_o (stage[l+1])
    );
  end

  // Feed-forward add of the saved chaining value, word by word
  always_comb begin
    fed_fwd = '0;
    for (int i = 0; i < 8; i++) begin
      fed_fwd[i*WORD +: WORD] = stage[UNROLL][i*WORD +: WORD] + chain_q[i*WORD +: WORD];
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    chain_d   = chain_q;
    digest_d  = digest_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    wk_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = h_in;
          chain_d = h_in;
          round_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wk_ready = 1'b1;
        if (wk_valid) begin
          work_d = stage[UNROLL];
          if (round_q == LAST_IDX) begin
            digest_d = fed_fwd;
            round_d  = '0;
            state_d  = ST_DONE;
          end else begin
            round_d = round_q + STEP;
          end
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      chain_q  <= '0;
      digest_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      chain_q  <= chain_d;
      digest_q <= digest_d;
      round_q  <= round_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign round_idx = round_q;
  assign digest    = digest_q;
  assign dbg_state = state_q;

endmodule
